// File: rtl/flappy_pio_pkg.sv
// Shared constants for the flap-button PIO: register word addresses and
// edge-capture mode encodings, plus a helper that decides whether an
// accepted level change counts as an edge event.
package flappy_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_UNUSED  = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_mode_e;

  // new_level is the value the debounced bit is about to take.
  function automatic logic edge_hit(input int mode, input logic new_level);
    logic hit;
    hit = 1'b0;
    if (mode == int'(EDGE_RISE))      hit = new_level;
    else if (mode == int'(EDGE_FALL)) hit = ~new_level;
    else if (mode == int'(EDGE_ANY))  hit = 1'b1;
    return hit;
  endfunction

endpackage

// File: rtl/flappy_debounce_bit.sv
// One button bit: 2-flop synchroniser, hold-time debounce counter and a
// single-cycle edge pulse that fires on the same clock edge the debounced
// value changes.
module flappy_debounce_bit
  import flappy_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int EDGE_MODE       = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic stable,
  output logic edge_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] count;
  logic          accept;

  // The new level has been held long enough; it is taken on this edge.
  assign accept     = (s2 != stable) && (count == COUNT_MAX);
  assign edge_pulse = accept && edge_hit(EDGE_MODE, s2);

  // Two-stage synchroniser for the asynchronous button input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Count consecutive cycles of disagreement; any agreement restarts the
  // count, so the counter never passes COUNT_MAX and cannot wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= 1'b0;
      count  <= '0;
    end else if (s2 == stable) begin
      count <= '0;
    end else if (accept) begin
      stable <= s2;
      count  <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/flappy_bird_control_flap_in.sv
// Avalon-MM input PIO for the flap button(s). Debounces each input bit,
// latches edge events in a W1C capture register and drives a level IRQ
// from the captured bits that are enabled in the mask register.
//
// Bus semantics: a write happens on the clock edge where chipselect is 1
// and write_n is 0; readdata is a pure function of address (no
// chipselect qualification, zero wait states, no read side effects).
module flappy_bird_control_flap_in
  import flappy_pio_pkg::*;
#(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int EDGE_MODE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] clear_bits;
  logic             wr;
  logic             unused_writedata;

  // Upper write-data bits have no register behind them.
  assign unused_writedata = ^writedata;

  assign wr         = chipselect & ~write_n;
  assign clear_bits = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    flappy_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .EDGE_MODE      (EDGE_MODE)
    ) u_bit (
      .clk       (clk),
      .reset_n   (reset_n),
      .raw       (in_port[i]),
      .stable    (stable[i]),
      .edge_pulse(edge_pulse[i])
    );
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= '0;
    end else if (wr && address == ADDR_IRQMASK) begin
      irqmask <= writedata[WIDTH-1:0];
    end
  end

  // Edge capture: a new event wins over a simultaneous W1C of that bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~clear_bits) | edge_pulse;
    end
  end

  // Read mux; unimplemented bits and the unused word read as zero.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = stable;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edge_capture;
      default:      readdata = '0;
    endcase
  end

  assign irq = |(edge_capture & irqmask);

endmodule

// File: tb/tb_flappy_bird_control_flap_in.sv
// Bench for the flap-button PIO: a 1-bit rising-edge instance (a) and a
// 2-bit any-edge instance (b), both with a 4-cycle debounce.
module tb_flappy_bird_control_flap_in;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        cs_a;
  logic        cs_b;
  logic        write_n;
  logic [31:0] writedata;
  logic [0:0]  in_a;
  logic [1:0]  in_b;
  logic [31:0] readdata_a;
  logic [31:0] readdata_b;
  logic        irq_a;
  logic        irq_b;

  int          compared;
  int          mismatched;
  logic [31:0] exp_q[$];
  logic [31:0] obs;
  logic [31:0] exp_v;

  flappy_bird_control_flap_in #(.WIDTH(1), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a),
    .write_n(write_n), .writedata(writedata), .in_port(in_a),
    .readdata(readdata_a), .irq(irq_a)
  );

  flappy_bird_control_flap_in #(.WIDTH(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b),
    .write_n(write_n), .writedata(writedata), .in_port(in_b),
    .readdata(readdata_b), .irq(irq_b)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; cs_a = 1'b1; write_n = 1'b0;
    tick(1);
    cs_a = 1'b0; write_n = 1'b1;
  endtask

  task automatic wr_b(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; cs_b = 1'b1; write_n = 1'b0;
    tick(1);
    cs_b = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_a(input logic [1:0] a, output logic [31:0] v);
    address = a;
    #1;
    v = readdata_a;
  endtask

  task automatic rd_b(input logic [1:0] a, output logic [31:0] v);
    address = a;
    #1;
    v = readdata_b;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_power_up;
    reset_n = 1'b0; address = 2'd0; cs_a = 1'b0; cs_b = 1'b0;
    write_n = 1'b1; writedata = '0; in_a = '0; in_b = '0;
    tick(3);
    reset_n = 1'b1;
    tick(1);
    exp_q.push_back(32'd0);
    rd_a(2'd1, obs); exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL unused_word: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_clean_press;
    in_a = 1'b1;
    tick(5);
    exp_q.push_back(32'd0);
    rd_a(2'd0, obs); exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL press_data_early: got %h want %h", obs, exp_v); end
    tick(1);
    exp_q.push_back(32'd1);
    rd_a(2'd0, obs); exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL press_data: got %h want %h", obs, exp_v); end
    exp_q.push_back(32'd1);
    rd_a(2'd3, obs); exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL press_edgecap: got %h want %h", obs, exp_v); end
    exp_q.push_back(32'd0);
    obs = {31'd0, irq_a}; exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL press_irq_masked: got %h want %h", obs, exp_v); end
    // Clear, then release: rising-only mode must not capture the release.
    wr_a(2'd3, 32'd1);
    in_a = 1'b0;
    tick(8);
    exp_q.push_back(32'd0);
    rd_a(2'd0, obs); exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL release_data: got %h want %h", obs, exp_v); end
    exp_q.push_back(32'd0);
    rd_a(2'd3, obs); exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL release_edgecap: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_bounce;
    in_a = 1'b1; tick(2);
    in_a = 1'b0; tick(2);
    in_a = 1'b1; tick(2);
    in_a = 1'b0; tick(2);
    exp_q.push_back(32'd0);
    rd_a(2'd3, obs); exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL bounce_no_edge: got %h want %h", obs, exp_v); end
    in_a = 1'b1;
    tick(5);
    exp_q.push_back(32'd0);
    rd_a(2'd0, obs); exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL bounce_data_early: got %h want %h", obs, exp_v); end
    tick(1);
    exp_q.push_back(32'd1);
    rd_a(2'd0, obs); exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL bounce_data: got %h want %h", obs, exp_v); end
    exp_q.push_back(32'd1);
    rd_a(2'd3, obs); exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL bounce_edgecap: got %h want %h", obs, exp_v); end
    wr_a(2'd3, 32'd1);
    in_a = 1'b0;
    tick(8);
  endtask

  task automatic test_irq;
    wr_a(2'd2, 32'hFFFF_FFFF);
    exp_q.push_back(32'd1);
    rd_a(2'd2, obs); exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL irqmask_read: got %h want %h", obs, exp_v); end
    in_a = 1'b1;
    tick(6);
    exp_q.push_back(32'd1);
    obs = {31'd0, irq_a}; exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL irq_raised: got %h want %h", obs, exp_v); end
    wr_a(2'd3, 32'd1);
    exp_q.push_back(32'd0);
    rd_a(2'd3, obs); exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL w1c_edgecap: got %h want %h", obs, exp_v); end
    exp_q.push_back(32'd0);
    obs = {31'd0, irq_a}; exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL w1c_irq: got %h want %h", obs, exp_v); end
    in_a = 1'b0;
    tick(8);
    exp_q.push_back(32'd0);
    rd_a(2'd3, obs); exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL irq_release_edgecap: got %h want %h", obs, exp_v); end
    exp_q.push_back(32'd0);
    obs = {31'd0, irq_a}; exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL irq_release_irq: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_collision;
    in_a = 1'b1;
    tick(5);
    // The W1C lands on the 6th rise, the same edge the rising event fires.
    wr_a(2'd3, 32'd1);
    exp_q.push_back(32'd1);
    rd_a(2'd3, obs); exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL collision_edgecap: got %h want %h", obs, exp_v); end
    exp_q.push_back(32'd1);
    obs = {31'd0, irq_a}; exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL collision_irq: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_reset;
    // Start a release debounce, then reset in the middle of it.
    in_a = 1'b0;
    tick(3);
    reset_n = 1'b0;
    exp_q.push_back(32'd0);
    rd_a(2'd0, obs); exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL reset_data: got %h want %h", obs, exp_v); end
    exp_q.push_back(32'd0);
    obs = {31'd0, irq_a}; exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL reset_irq: got %h want %h", obs, exp_v); end
    in_a = 1'b1;
    tick(2);
    reset_n = 1'b1;
    exp_q.push_back(32'd0);
    rd_a(2'd2, obs); exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL reset_irqmask: got %h want %h", obs, exp_v); end
    exp_q.push_back(32'd0);
    rd_a(2'd3, obs); exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL reset_edgecap: got %h want %h", obs, exp_v); end
    // Button held through reset release: first debounce is a rising edge.
    tick(5);
    exp_q.push_back(32'd0);
    rd_a(2'd0, obs); exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL held_data_early: got %h want %h", obs, exp_v); end
    tick(1);
    exp_q.push_back(32'd1);
    rd_a(2'd0, obs); exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL held_data: got %h want %h", obs, exp_v); end
    exp_q.push_back(32'd1);
    rd_a(2'd3, obs); exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL held_edgecap: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_edge_any;
    in_b = 2'b01; tick(6);
    exp_q.push_back(32'd1);
    rd_b(2'd3, obs); exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL any_bit0_press: got %h want %h", obs, exp_v); end
    in_b = 2'b00; tick(6);
    in_b = 2'b10; tick(6);
    exp_q.push_back(32'd2);
    rd_b(2'd0, obs); exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL any_data_bit1: got %h want %h", obs, exp_v); end
    in_b = 2'b00; tick(6);
    exp_q.push_back(32'd3);
    rd_b(2'd3, obs); exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL any_edgecap_both: got %h want %h", obs, exp_v); end
    wr_b(2'd3, 32'h1);
    exp_q.push_back(32'd2);
    rd_b(2'd3, obs); exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL any_w1c_bit0: got %h want %h", obs, exp_v); end
    wr_b(2'd2, 32'h2);
    exp_q.push_back(32'd1);
    obs = {31'd0, irq_b}; exp_v = exp_q.pop_front(); compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL any_irq_bit1: got %h want %h", obs, exp_v); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    compared   = 0;
    mismatched = 0;
    test_power_up();
    test_clean_press();
    test_bounce();
    test_irq();
    test_collision();
    test_reset();
    test_edge_any();
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
